// File: rtl/div_if.sv
// Divider request/response bundle between the execution stage (master) and div_16bit (slave).
// Handshake: start is sampled only on an edge where busy=0; done pulses one cycle with results valid.
interface div_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             operator;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, A, B, operator,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, A, B, operator,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/div_16bit.sv
// Restoring shift-and-subtract divider, one quotient bit per clock, signed or unsigned.
// Divide-by-zero resolves in the IDLE edge; nonzero divisors take ITER CALC edges plus one FIX edge.
module div_16bit #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output logic [1:0] dbg_state_o
);
  localparam int CW = $clog2(ITER);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    state_d    = state_q;
    dvs_d      = dvs_q;
    dvd_d      = dvd_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    ovf_pend_d = ovf_pend_q;
    quo_d      = quo_q;
    rmd_d      = rmd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    a_mag   = (bus.operator && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag   = (bus.operator && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    // Partial remainder stays below the divisor, so WIDTH+1 bits hold the shifted value.
    shifted = {rem_q, dvd_q[WIDTH-1]};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.B == '0) begin
            quo_d  = '1;
            rmd_d  = bus.A;
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            dvs_d      = b_mag;
            dvd_d      = a_mag;
            rem_d      = '0;
            cnt_d      = '0;
            neg_quo_d  = bus.operator & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_rem_d  = bus.operator & bus.A[WIDTH-1];
            ovf_pend_d = bus.operator && (bus.A == MIN_NEG) && (bus.B == '1);
            busy_d     = 1'b1;
            state_d    = CALC;
          end
        end
      end
      CALC: begin
        if (shifted >= {1'b0, dvs_q}) begin
          rem_d = shifted[WIDTH-1:0] - dvs_q;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        quo_d   = neg_quo_q ? -dvd_q : dvd_q;
        rmd_d   = neg_rem_q ? -rem_q : rem_q;
        ovf_d   = ovf_pend_q;
        dbz_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dvs_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      quo_q      <= '0;
      rmd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvs_q      <= dvs_d;
      dvd_q      <= dvd_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      ovf_pend_q <= ovf_pend_d;
      quo_q      <= quo_d;
      rmd_q      <= rmd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_div_16bit.sv
// Bench for div_16bit: cycle-level behavioural model from plain integer division,
// per-cycle output compare, directed operand cases and randomized start traffic.
module tb_div_16bit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] dbg_state;

  div_if #(.WIDTH(16)) bus ();

  div_16bit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result packed as {quotient, remainder, div_by_zero, overflow}.
  function automatic logic [33:0] ref_div(input logic [15:0] a, input logic [15:0] b, input logic op);
    int sa, sb, q, r;
    if (b == 16'd0) return {16'hFFFF, a, 1'b1, 1'b0};
    if (!op) return {a / b, a % b, 2'b00};
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sa == -32768 && sb == -1) return {16'h8000, 16'h0000, 2'b01};
    q = sa / sb;
    r = sa % sb;
    return {q[15:0], r[15:0], 2'b00};
  endfunction

  // ---------------- behavioural model ----------------
  logic [15:0] m_quo = '0, m_rmd = '0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0, m_ovf = 1'b0;
  int          m_cnt = 0;
  logic [33:0] m_pend = '0;
  logic [33:0] m_res;
  logic [33:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_quo <= '0; m_rmd <= '0; m_busy <= 1'b0; m_done <= 1'b0;
      m_dbz <= 1'b0; m_ovf <= 1'b0; m_cnt <= 0;
      exp_q.delete();
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (bus.start) begin
          m_res = ref_div(bus.A, bus.B, bus.operator);
          exp_q.push_back(m_res);
          if (bus.B == 16'd0) begin
            {m_quo, m_rmd, m_dbz, m_ovf} <= m_res;
            m_done <= 1'b1;
          end else begin
            m_pend <= m_res;
            m_busy <= 1'b1;
            m_cnt  <= 17;
          end
        end
      end else begin
        if (m_cnt == 1) begin
          {m_quo, m_rmd, m_dbz, m_ovf} <= m_pend;
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // ---------------- per-cycle compare / scoreboard ----------------
  logic [33:0] sb_e;
  always @(negedge clk) begin
    check("cycle", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow},
                   {m_quo, m_rmd, m_busy, m_done, m_dbz, m_ovf});
    if (bus.done) begin
      if (exp_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
      else begin
        sb_e = exp_q.pop_front();
        check("scoreboard", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, sb_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic op);
    bus.start = 1'b1; bus.A = a; bus.B = b; bus.operator = op;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cyc, output bit got);
    busy_cyc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cyc++;
      if (bus.done) got = 1'b1;
    end
    if (!got) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_check(input string name, input logic [15:0] a, input logic [15:0] b, input logic op,
                           input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                           input logic eovf, input int ebusy);
    int bc; bit got;
    do_op(a, b, op);
    wait_done(bc, got);
    check(name, {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, {eq, er, edbz, eovf});
    check({name, "_busy_cycles"}, 64'(bc), 64'(ebusy));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc; bit got;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.operator = 1'b0;

    // Model pins
    check("pin_u100_7",   64'(ref_div(16'd100, 16'd7, 1'b0)),        64'({16'd14, 16'd2, 2'b00}));
    check("pin_s-7_2",    64'(ref_div(16'hFFF9, 16'h0002, 1'b1)),    64'({16'hFFFD, 16'hFFFF, 2'b00}));
    check("pin_s7_-2",    64'(ref_div(16'h0007, 16'hFFFE, 1'b1)),    64'({16'hFFFD, 16'h0001, 2'b00}));
    check("pin_s_ovf",    64'(ref_div(16'h8000, 16'hFFFF, 1'b1)),    64'({16'h8000, 16'h0000, 2'b01}));
    check("pin_u_8000",   64'(ref_div(16'h8000, 16'hFFFF, 1'b0)),    64'({16'h0000, 16'h8000, 2'b00}));

    // Reset
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_check("u_100_7",   16'd100,   16'd7,     1'b0, 16'd14,    16'd2,     1'b0, 1'b0, 17);
    run_check("s_m7_2",    16'hFFF9,  16'h0002,  1'b1, 16'hFFFD,  16'hFFFF,  1'b0, 1'b0, 17);
    run_check("s_7_m2",    16'h0007,  16'hFFFE,  1'b1, 16'hFFFD,  16'h0001,  1'b0, 1'b0, 17);
    run_check("s_ovf",     16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'h0000,  1'b0, 1'b1, 17);
    run_check("u_8000",    16'h8000,  16'hFFFF,  1'b0, 16'h0000,  16'h8000,  1'b0, 1'b0, 17);
    run_check("div_zero",  16'h1234,  16'h0000,  1'b0, 16'hFFFF,  16'h1234,  1'b1, 1'b0, 0);
    run_check("u_max_1",   16'hFFFF,  16'h0001,  1'b0, 16'hFFFF,  16'h0000,  1'b0, 1'b0, 17);

    // Start while busy is ignored; start in the done cycle is accepted
    do_op(16'hFFFF, 16'd1, 1'b0);
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1; bus.A = 16'd9; bus.B = 16'd3; bus.operator = 1'b0;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(bc, got);
    check("busy_start_ignored", {bus.quotient, bus.remainder}, {16'hFFFF, 16'h0000});
    run_check("back_to_back", 16'd9, 16'd3, 1'b0, 16'd3, 16'd0, 1'b0, 1'b0, 17);

    // Reset mid-operation
    do_op(16'd1000, 16'd10, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("mid_reset_clear", {bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    run_check("after_reset", 16'd1000, 16'd10, 1'b0, 16'd100, 16'd0, 1'b0, 1'b0, 17);

    // Randomized traffic, including starts while busy and zero divisors
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.start    = ($urandom_range(0, 2) == 0);
      bus.A        = 16'($urandom);
      bus.operator = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: bus.B = 16'd0;
        1: begin bus.A = 16'h8000; bus.B = 16'hFFFF; end
        2, 3: bus.B = 16'($urandom_range(1, 15));
        4: bus.B = {12'hFFF, 4'($urandom)};
        default: bus.B = 16'($urandom);
      endcase
    end
    #1 bus.start = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
